line_buffer_rot: RTL

- Parametrised rotating line buffer for a KxK convolution front end, with KER_SIZE+1 single-port row banks of NW words each.
- Pixels stream in one word per beat; completed rows are held in banks.
- Once KER_SIZE rows are held, a column read returns a KER_SIZE-word vertical slice, ordered oldest to newest.
- A consumer release pulse retires the oldest row. Sits between the input pixel stream and the PE array.

---
 rtl/line_buffer_rot.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/line_buffer_rot.sv
// Rotating KER_SIZE+1 bank line buffer: streams pixel rows in, serves KER_SIZE-word column slices oldest-first.
// Latency: column read returns 1 cycle after rd_en (2 cycles when LINE_BUF_OUT_REG_EN is defined).
// Backpressure: in_ready drops while all NB banks hold complete rows; row_release frees the oldest one.
module line_buffer_rot #(
  parameter int KER_SIZE = 3,
  parameter int DW       = 32,
  parameter int NW       = 32,
  parameter int AW       = $clog2(NW)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   clear,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DW-1:0]          in_data,
  input  logic                   rd_en,
  input  logic [AW-1:0]          rd_addr,
  output logic                   out_valid,
  output logic [KER_SIZE*DW-1:0] out_data,
  input  logic                   row_release,
  output logic                   rows_ready,
  output logic [$clog2(KER_SIZE+2)-1:0] filled
);
  localparam int NB = KER_SIZE + 1;
  localparam int BW = $clog2(NB);
  localparam int FW = $clog2(NB + 1);
  localparam int KW = KER_SIZE * DW;

  logic [BW-1:0] wr_bank_q, wr_bank_d;
  logic [BW-1:0] rd_base_q, rd_base_d;
  logic [BW-1:0] base_snap_q, base_snap_d;
  logic [AW-1:0] wr_col_q, wr_col_d;
  logic [FW-1:0] filled_q, filled_d;
  logic          rd_vld_q, rd_vld_d;
  logic [DW-1:0] bank_rdata_q [NB];
  logic [DW-1:0] bank_rdata_d [NB];
  logic [NB-1:0] wr_sel, rd_sel;
  logic [BW-1:0] slot [NB];
  logic [BW-1:0] slice_idx [KER_SIZE];
  logic [KW-1:0] slice_data;
  logic          wr_fire, rd_fire, row_done, rel;

  assign in_ready   = (filled_q < FW'(NB));
  assign rows_ready = (filled_q >= FW'(KER_SIZE));
  assign filled     = filled_q;

  assign wr_fire  = in_valid && in_ready && !clear;
  assign row_done = wr_fire && (wr_col_q == AW'(NW - 1));
  assign rel      = row_release && (filled_q != '0) && !clear;
  assign rd_fire  = rd_en && rows_ready && !clear;

  always_comb begin
    wr_bank_d   = wr_bank_q;
    rd_base_d   = rd_base_q;
    base_snap_d = base_snap_q;
    wr_col_d    = wr_col_q;
    filled_d    = filled_q;
    rd_vld_d    = 1'b0;
    if (clear) begin
      wr_bank_d   = '0;
      rd_base_d   = '0;
      base_snap_d = '0;
      wr_col_d    = '0;
      filled_d    = '0;
    end else begin
      if (wr_fire) begin
        wr_col_d = row_done ? '0 : wr_col_q + 1'b1;
        if (row_done) wr_bank_d = (wr_bank_q == BW'(NB - 1)) ? '0 : wr_bank_q + 1'b1;
      end
      if (rel) rd_base_d = (rd_base_q == BW'(NB - 1)) ? '0 : rd_base_q + 1'b1;
      if (row_done && !rel) filled_d = filled_q + 1'b1;
      else if (rel && !row_done) filled_d = filled_q - 1'b1;
      // Snapshot the pre-release base so a same-cycle release cannot skew the slice order.
      rd_vld_d = rd_fire;
      if (rd_fire) base_snap_d = rd_base_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_bank_q   <= '0;
      rd_base_q   <= '0;
      base_snap_q <= '0;
      wr_col_q    <= '0;
      filled_q    <= '0;
      rd_vld_q    <= 1'b0;
    end else begin
      wr_bank_q   <= wr_bank_d;
      rd_base_q   <= rd_base_d;
      base_snap_q <= base_snap_d;
      wr_col_q    <= wr_col_d;
      filled_q    <= filled_d;
      rd_vld_q    <= rd_vld_d;
    end
  end

  // Each bank sees at most one of write or read per cycle: the write bank is never a held bank while writable.
  for (genvar b = 0; b < NB; b++) begin : g_bank
    logic [DW-1:0] mem [NW];

    assign slot[b]   = BW'((b + NB - int'(rd_base_q)) % NB);
    assign wr_sel[b] = wr_fire && (wr_bank_q == BW'(b));
    assign rd_sel[b] = rd_fire && (slot[b] < BW'(KER_SIZE));
    assign bank_rdata_d[b] = clear     ? '0 :
                             rd_sel[b] ? mem[rd_addr] : bank_rdata_q[b];

    always_ff @(posedge clk) begin
      if (wr_sel[b]) mem[wr_col_q] <= in_data;
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) bank_rdata_q[b] <= '0;
      else       bank_rdata_q[b] <= bank_rdata_d[b];
    end
  end

  for (genvar i = 0; i < KER_SIZE; i++) begin : g_slice
    assign slice_idx[i] = BW'((int'(base_snap_q) + i) % NB);
    assign slice_data[i*DW +: DW] = bank_rdata_q[slice_idx[i]];
  end

`ifdef LINE_BUF_OUT_REG_EN
  logic          out_vld_q, out_vld_d;
  logic [KW-1:0] out_dat_q, out_dat_d;

  always_comb begin
    out_vld_d = clear ? 1'b0 : rd_vld_q;
    out_dat_d = out_dat_q;
    if (clear)         out_dat_d = '0;
    else if (rd_vld_q) out_dat_d = slice_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
    end else begin
      out_vld_q <= out_vld_d;
      out_dat_q <= out_dat_d;
    end
  end

  assign out_valid = out_vld_q;
  assign out_data  = out_dat_q;
`else
  assign out_valid = rd_vld_q;
  assign out_data  = slice_data;
`endif

endmodule
